// File: rtl/bitwise_accum_unit.sv
// bitwise_accum_unit
//   One-stage registered bitwise operation unit with valid/ready handshakes
//   on both sides. Each accepted beat computes AND / OR / XOR / bit-clear of
//   an operand X with in_b. X is in_a, or the internal accumulator when
//   continuing an accumulate chain. The result is registered together with
//   its OR/AND/XOR reductions and the accumulate-chain beat count.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b            operands (in_a ignored when continuing a chain)
//   in_op                 00 AND, 01 OR, 10 XOR, 11 bit-clear (X & ~B)
//   in_acc, in_clr        accumulate mode; in_clr seeds a new chain from in_a
//   out_valid / out_ready output handshake
//   out_result            registered result
//   out_red_or/and/xor    reductions of out_result
//   out_count             beats in current accumulate chain (saturating)
module bitwise_accum_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_op,
    input  logic               in_acc,
    input  logic               in_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_red_or,
    output logic               out_red_and,
    output logic               out_red_xor,
    output logic [COUNT_W-1:0] out_count
);

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   op_x;
    logic [WIDTH-1:0]   next_result;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] next_count;
    logic               accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_x = (in_acc && !in_clr) ? acc_q : in_a;

        case (in_op)
            2'b00:   next_result = op_x & in_b;
            2'b01:   next_result = op_x | in_b;
            2'b10:   next_result = op_x ^ in_b;
            default: next_result = op_x & ~in_b;
        endcase

        next_count = count_q;
        if (in_acc) begin
            if (in_clr)
                next_count = COUNT_W'(1);
            else if (!(&count_q))
                next_count = count_q + 1'b1;
        end
    end

    // The chain counter is only ever shown as "value after the accepted
    // beat", and non-accumulate beats leave it unchanged, so one register
    // serves both as the chain state and as out_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_red_or  <= 1'b0;
            out_red_and <= 1'b0;
            out_red_xor <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_result  <= next_result;
                out_red_or  <= |next_result;
                out_red_and <= &next_result;
                out_red_xor <= ^next_result;
                count_q     <= next_count;
                if (in_acc)
                    acc_q <= next_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_count = count_q;

endmodule

// File: tb/tb_bitwise_accum_unit.sv
// tb_bitwise_accum_unit
//   Drives two instances (8-bit / 2-bit counter and 3-bit / 4-bit counter)
//   with directed and random beats and compares every output against a
//   beat-level reference model kept in plain integers.
module tb_bitwise_accum_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=8, COUNT_W=2
    logic       p_in_valid, p_in_ready, p_in_acc, p_in_clr;
    logic [7:0] p_in_a, p_in_b, p_out_result;
    logic [1:0] p_in_op, p_out_count;
    logic       p_out_valid, p_out_ready, p_out_red_or, p_out_red_and, p_out_red_xor;

    // Instance 1: WIDTH=3, COUNT_W=4
    logic       t_in_valid, t_in_ready, t_in_acc, t_in_clr;
    logic [2:0] t_in_a, t_in_b, t_out_result;
    logic [1:0] t_in_op;
    logic [3:0] t_out_count;
    logic       t_out_valid, t_out_ready, t_out_red_or, t_out_red_and, t_out_red_xor;

    bitwise_accum_unit #(.WIDTH(8), .COUNT_W(2)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_a(p_in_a), .in_b(p_in_b), .in_op(p_in_op),
        .in_acc(p_in_acc), .in_clr(p_in_clr),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_result(p_out_result), .out_red_or(p_out_red_or),
        .out_red_and(p_out_red_and), .out_red_xor(p_out_red_xor),
        .out_count(p_out_count)
    );

    bitwise_accum_unit #(.WIDTH(3), .COUNT_W(4)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_a(t_in_a), .in_b(t_in_b), .in_op(t_in_op),
        .in_acc(t_in_acc), .in_clr(t_in_clr),
        .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_result(t_out_result), .out_red_or(t_out_red_or),
        .out_red_and(t_out_red_and), .out_red_xor(t_out_red_xor),
        .out_count(t_out_count)
    );

    int checks = 0;
    int errors = 0;

    int unsigned mw[2]   = '{8, 3};
    int unsigned cmax[2] = '{3, 15};

    // Reference model state, as seen after the most recent clock edge
    bit          mv[2];
    int unsigned mres[2], mcnt[2], macc[2];

    // Inputs currently driven to each instance
    bit          dv[2], dacc[2], dclr[2], dordy[2];
    int unsigned da[2], db[2], dop[2];

    function automatic int unsigned mask(input int d);
        return (32'd1 << mw[d]) - 32'd1;
    endfunction

    function automatic int unsigned popcount(input int unsigned v, input int unsigned w);
        int unsigned n = 0;
        for (int unsigned i = 0; i < w; i++)
            n += (v >> i) & 32'd1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set(input int d, input bit v, input int unsigned a, input int unsigned b,
                       input int unsigned op, input bit acc, input bit clr, input bit ordy);
        dv[d] = v; da[d] = a; db[d] = b; dop[d] = op % 4;
        dacc[d] = acc; dclr[d] = clr; dordy[d] = ordy;
    endtask

    task automatic apply();
        p_in_valid = dv[0]; p_in_a = da[0][7:0]; p_in_b = db[0][7:0]; p_in_op = dop[0][1:0];
        p_in_acc = dacc[0]; p_in_clr = dclr[0]; p_out_ready = dordy[0];
        t_in_valid = dv[1]; t_in_a = da[1][2:0]; t_in_b = db[1][2:0]; t_in_op = dop[1][1:0];
        t_in_acc = dacc[1]; t_in_clr = dclr[1]; t_out_ready = dordy[1];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mres[d] = 0; mcnt[d] = 0; macc[d] = 0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [31:0] ov, ores, oor, oand, oxor, ocnt, ordy;
        int unsigned pc;
        if (d == 0) begin
            ov = 32'(p_out_valid); ores = 32'(p_out_result); oor = 32'(p_out_red_or);
            oand = 32'(p_out_red_and); oxor = 32'(p_out_red_xor);
            ocnt = 32'(p_out_count); ordy = 32'(p_in_ready);
        end else begin
            ov = 32'(t_out_valid); ores = 32'(t_out_result); oor = 32'(t_out_red_or);
            oand = 32'(t_out_red_and); oxor = 32'(t_out_red_xor);
            ocnt = 32'(t_out_count); ordy = 32'(t_in_ready);
        end
        pc = popcount(mres[d], mw[d]);
        chk($sformatf("d%0d_out_valid", d), ov, 32'(mv[d]));
        chk($sformatf("d%0d_out_result", d), ores, mres[d]);
        chk($sformatf("d%0d_red_or", d), oor, (pc != 0) ? 32'd1 : 32'd0);
        chk($sformatf("d%0d_red_and", d), oand, (pc == mw[d]) ? 32'd1 : 32'd0);
        chk($sformatf("d%0d_red_xor", d), oxor, pc % 2);
        chk($sformatf("d%0d_out_count", d), ocnt, mcnt[d]);
        chk($sformatf("d%0d_in_ready", d), ordy, (!mv[d] || dordy[d]) ? 32'd1 : 32'd0);
    endtask

    // Beat-level behaviour: what one clock edge does given current inputs
    task automatic model_step(input int d);
        bit          rdy;
        int unsigned x, r;
        rdy = !mv[d] || dordy[d];
        if (dv[d] && rdy) begin
            x = (dacc[d] && !dclr[d]) ? macc[d] : (da[d] & mask(d));
            case (dop[d])
                0:       r = x & db[d];
                1:       r = x | db[d];
                2:       r = x ^ db[d];
                default: r = x & ~db[d];
            endcase
            r = r & mask(d);
            mres[d] = r;
            mv[d]   = 1'b1;
            if (dacc[d]) begin
                macc[d] = r;
                if (dclr[d])
                    mcnt[d] = 1;
                else
                    mcnt[d] = (mcnt[d] + 1 > cmax[d]) ? cmax[d] : mcnt[d] + 1;
            end
        end else if (dordy[d]) begin
            mv[d] = 1'b0;
        end
    endtask

    // Called at posedge+1: drive, check the state left by the last edge,
    // advance the model, then move to the next posedge+1.
    task automatic tick();
        apply();
        #1;
        check_dut(0);
        check_dut(1);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        set(d, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle(0);
        idle(1);
        apply();
        model_reset();
        #2;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 3-bit instance: AND, then OR / XOR / bit-clear back to back
        set(1, 1'b1, 3'b011, 3'b100, 0, 1'b0, 1'b0, 1'b1); tick();
        idle(1); tick(); tick();
        set(1, 1'b1, 3'b111, 3'b101, 1, 1'b0, 1'b0, 1'b1); tick();
        set(1, 1'b1, 3'b011, 3'b011, 2, 1'b0, 1'b0, 1'b1); tick();
        set(1, 1'b1, 3'b111, 3'b101, 3, 1'b0, 1'b0, 1'b1); tick();
        idle(1); tick(); tick();

        // 8-bit accumulate chain with an intervening plain beat
        set(0, 1'b1, 8'h01, 8'h10, 1, 1'b1, 1'b1, 1'b1); tick();
        set(0, 1'b1, 8'hEE, 8'h04, 1, 1'b1, 1'b0, 1'b1); tick();
        set(0, 1'b1, 8'h5A, 8'h0F, 0, 1'b1, 1'b0, 1'b1); tick();
        set(0, 1'b1, 8'hFF, 8'h00, 1, 1'b0, 1'b0, 1'b1); tick();
        set(0, 1'b1, 8'h33, 8'h05, 2, 1'b1, 1'b0, 1'b1); tick();
        idle(0); tick();
        chk("chain_final_result", 32'(p_out_result), 32'h00);
        tick();

        // Backpressure: stall three cycles with changing operands, then stream
        set(0, 1'b1, 8'h3C, 8'h0F, 1, 1'b1, 1'b1, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            set(0, 1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0); tick();
        end
        for (int i = 0; i < 6; i++) begin
            set(0, 1'b1, $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1, 1'b0, 1'b1); tick();
        end
        idle(0); tick(); tick();

        // Counter saturation on the 2-bit counter
        set(0, 1'b1, 8'h81, 8'h02, 1, 1'b1, 1'b1, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            set(0, 1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b1); tick();
        end
        idle(0); tick();
        chk("saturated_count", 32'(p_out_count), 32'd3);
        tick();

        // Asynchronous reset during a stall holding 0xA5
        set(0, 1'b1, 8'hA5, 8'h00, 1, 1'b1, 1'b1, 1'b1); tick();
        set(0, 1'b1, 8'h11, 8'h22, 0, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("stalled_result", 32'(p_out_result), 32'hA5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
        check_dut(0);
        rst_n = 1'b1;
        set(0, 1'b1, 8'h77, 8'h3C, 1, 1'b1, 1'b0, 1'b1); tick();
        idle(0); tick();
        chk("post_reset_result", 32'(p_out_result), 32'h3C);
        tick();

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                set(d, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0);
            tick();
        end
        idle(0);
        idle(1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
